data_memory_init: RTL and testbench

- Parametrised single-port synchronous data memory for the course-project datapath.
- Successor to the fixed 4x16 data memory, generalised in width and depth.
- Adds a multi-cycle hardware initialisation sequencer with a busy flag and a software re-init request.
- Adds a registered read with a valid strobe, and defined read/write collision behaviour.

---
 rtl/dmem_pkg.sv | 14 +
 rtl/dmem_array.sv | 38 +++
 rtl/data_memory_init.sv | 86 ++++++++
 tb/tb_data_memory_init.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and init-pattern helper for the data memory
package dmem_pkg;

  typedef enum logic [0:0] {INIT = 1'b0, IDLE = 1'b1} dmem_state_t;

  localparam int INIT_IDENTITY = 0;
  localparam int INIT_ZERO     = 1;

  // Returned at 32 bits; the caller truncates or zero-extends to its word width.
  function automatic logic [31:0] init_pattern(input int mode, input int idx);
    return (mode == INIT_ZERO) ? 32'd0 : 32'(idx);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - storage with one synchronous write port and a read-first registered read
module dmem_array #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] i_add,
  input  logic              i_we,
  input  logic [DATA_W-1:0] i_wd,
  input  logic              i_re,
  output logic [DATA_W-1:0] o_rd
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rd;

  // Contents are deliberately left out of reset; the init sweep rewrites them.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_add] <= i_wd;
    end
  end

  // Sampling the array before this edge's write lands gives read-first collisions.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rd <= '0;
    end else if (i_re) begin
      r_rd <= r_mem[i_add];
    end
  end

  assign o_rd = r_rd;

endmodule

// File: rtl/data_memory_init.sv
// rtl/data_memory_init.sv - data memory with hardware init sweep, busy flag and registered read
module data_memory_init
  import dmem_pkg::*;
#(
  parameter int DATA_W    = 4,
  parameter int ADDR_W    = 4,
  parameter int INIT_MODE = INIT_IDENTITY
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] M_add,
  input  logic              M_we,
  input  logic              M_re,
  input  logic [DATA_W-1:0] M_wd,
  input  logic              M_init,
  output logic [DATA_W-1:0] M_rd,
  output logic              M_rvalid,
  output logic              M_busy
);

  localparam int                DEPTH     = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  dmem_state_t       r_state;
  logic [ADDR_W-1:0] r_cnt;
  logic              r_rvalid;
  logic              r_busy;

  logic              w_sweep;
  logic              w_req_ok;
  logic              w_arr_we;
  logic              w_arr_re;
  logic [ADDR_W-1:0] w_arr_add;
  logic [DATA_W-1:0] w_arr_wd;
  logic [DATA_W-1:0] w_pattern;

  assign w_sweep   = (r_state == INIT);
  // A re-init request in IDLE wins over any access issued in the same cycle.
  assign w_req_ok  = (r_state == IDLE) && !M_init;
  assign w_pattern = DATA_W'(init_pattern(INIT_MODE, int'(r_cnt)));

  assign w_arr_we  = reset && (w_sweep || (w_req_ok && M_we));
  assign w_arr_re  = reset && w_req_ok && M_re;
  assign w_arr_add = w_sweep ? r_cnt : M_add;
  assign w_arr_wd  = w_sweep ? w_pattern : M_wd;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= INIT;
      r_cnt    <= '0;
      r_rvalid <= 1'b0;
      r_busy   <= 1'b1;
    end else if (r_state == INIT) begin
      r_rvalid <= 1'b0;
      r_cnt    <= r_cnt + ADDR_W'(1);
      if (r_cnt == LAST_ADDR) begin
        r_state <= IDLE;
        r_busy  <= 1'b0;
      end
    end else if (M_init) begin
      r_state  <= INIT;
      r_cnt    <= '0;
      r_busy   <= 1'b1;
      r_rvalid <= 1'b0;
    end else begin
      r_rvalid <= M_re;
    end
  end

  dmem_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk   (clk),
    .reset (reset),
    .i_add (w_arr_add),
    .i_we  (w_arr_we),
    .i_wd  (w_arr_wd),
    .i_re  (w_arr_re),
    .o_rd  (M_rd)
  );

  assign M_rvalid = r_rvalid;
  assign M_busy   = r_busy;

endmodule

// File: tb/tb_data_memory_init.sv
// tb/tb_data_memory_init.sv - scoreboard bench for data_memory_init (identity 4x16 and zero 8x8)
module tb_data_memory_init;

  logic       clk;
  logic       reset1, we1, re1, init1;
  logic [3:0] add1, wd1, rd1;
  logic       rvalid1, busy1;
  logic       reset2, we2, re2, init2;
  logic [2:0] add2;
  logic [7:0] wd2, rd2;
  logic       rvalid2, busy2;

  logic [3:0] exp1 [$];
  logic [7:0] exp2 [$];
  logic [3:0] e1;
  logic [7:0] e2;
  int n_pass;
  int n_total;

  data_memory_init #(.DATA_W(4), .ADDR_W(4), .INIT_MODE(0)) dut1 (
    .clk(clk), .reset(reset1), .M_add(add1), .M_we(we1), .M_re(re1), .M_wd(wd1),
    .M_init(init1), .M_rd(rd1), .M_rvalid(rvalid1), .M_busy(busy1)
  );

  data_memory_init #(.DATA_W(8), .ADDR_W(3), .INIT_MODE(1)) dut2 (
    .clk(clk), .reset(reset2), .M_add(add2), .M_we(we2), .M_re(re2), .M_wd(wd2),
    .M_init(init2), .M_rd(rd2), .M_rvalid(rvalid2), .M_busy(busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rvalid1 === 1'b1) begin
      n_total++;
      if (exp1.size() == 0) begin
        $display("FAIL rd1_unexpected: M_rvalid=1 with no accepted read, M_rd=%h", rd1);
      end else begin
        e1 = exp1.pop_front();
        if (rd1 !== e1) $display("FAIL rd1_data: got %h expected %h", rd1, e1);
        else n_pass++;
      end
    end
    if (rvalid2 === 1'b1) begin
      n_total++;
      if (exp2.size() == 0) begin
        $display("FAIL rd2_unexpected: M_rvalid=1 with no accepted read, M_rd=%h", rd2);
      end else begin
        e2 = exp2.pop_front();
        if (rd2 !== e2) $display("FAIL rd2_data: got %h expected %h", rd2, e2);
        else n_pass++;
      end
    end
  end

  task automatic wait_busy1(output int n);
    n = 0;
    while (busy1 === 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    int n;
    reset1 = 1'b0;
    repeat (2) @(negedge clk);
    n_total++;
    if (busy1 !== 1'b1 || rvalid1 !== 1'b0 || rd1 !== 4'h0)
      $display("FAIL reset_state: busy=%b rvalid=%b rd=%h expected 1 0 0", busy1, rvalid1, rd1);
    else n_pass++;
    reset1 = 1'b1;
    wait_busy1(n);
    n_total++;
    if (n !== 16) $display("FAIL init_busy_len: got %0d cycles expected 16", n);
    else n_pass++;
    for (int i = 0; i < 16; i++) begin
      re1 = 1'b1;
      add1 = 4'(i);
      exp1.push_back(4'(i));
      @(negedge clk);
    end
    re1 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_write_read;
    we1 = 1'b1; add1 = 4'd3; wd1 = 4'hA;
    @(negedge clk);
    we1 = 1'b0; re1 = 1'b1;
    exp1.push_back(4'hA);
    @(negedge clk);
    re1 = 1'b0;
    @(negedge clk);
    n_total++;
    if (rvalid1 !== 1'b0 || rd1 !== 4'hA)
      $display("FAIL read_hold: rvalid=%b rd=%h expected 0 a", rvalid1, rd1);
    else n_pass++;
  endtask

  task automatic test_collision;
    we1 = 1'b1; re1 = 1'b1; add1 = 4'd5; wd1 = 4'h9;
    exp1.push_back(4'h5);
    @(negedge clk);
    we1 = 1'b0;
    exp1.push_back(4'h9);
    @(negedge clk);
    re1 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_init;
    int n;
    reset1 = 1'b0;
    @(negedge clk);
    reset1 = 1'b1;
    we1 = 1'b1; re1 = 1'b1; init1 = 1'b1; add1 = 4'd2; wd1 = 4'hF;
    repeat (7) @(negedge clk);
    reset1 = 1'b0;
    @(negedge clk);
    n_total++;
    if (busy1 !== 1'b1 || rvalid1 !== 1'b0 || rd1 !== 4'h0)
      $display("FAIL midinit_reset_state: busy=%b rvalid=%b rd=%h expected 1 0 0", busy1, rvalid1, rd1);
    else n_pass++;
    reset1 = 1'b1;
    wait_busy1(n);
    we1 = 1'b0; re1 = 1'b0; init1 = 1'b0;
    n_total++;
    if (n !== 16) $display("FAIL restart_busy_len: got %0d cycles expected 16", n);
    else n_pass++;
    re1 = 1'b1; add1 = 4'd2;
    exp1.push_back(4'h2);
    @(negedge clk);
    re1 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_init_pulse;
    int n;
    we1 = 1'b1; add1 = 4'd8; wd1 = 4'h0;
    @(negedge clk);
    we1 = 1'b0; init1 = 1'b1; re1 = 1'b1;
    @(negedge clk);
    init1 = 1'b0; re1 = 1'b0;
    n_total++;
    if (busy1 !== 1'b1 || rvalid1 !== 1'b0)
      $display("FAIL init_pulse_state: busy=%b rvalid=%b expected 1 0", busy1, rvalid1);
    else n_pass++;
    wait_busy1(n);
    n_total++;
    if (n !== 16) $display("FAIL reinit_busy_len: got %0d cycles expected 16", n);
    else n_pass++;
    re1 = 1'b1; add1 = 4'd8;
    exp1.push_back(4'h8);
    @(negedge clk);
    re1 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_zero_mode;
    int n;
    reset2 = 1'b1;
    n = 0;
    while (busy2 === 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
    n_total++;
    if (n !== 8) $display("FAIL zero_busy_len: got %0d cycles expected 8", n);
    else n_pass++;
    for (int i = 0; i < 8; i++) begin
      re2 = 1'b1;
      add2 = 3'(i);
      exp2.push_back(8'h00);
      @(negedge clk);
    end
    re2 = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    n_pass = 0; n_total = 0;
    reset1 = 1'b0; we1 = 1'b0; re1 = 1'b0; init1 = 1'b0; add1 = '0; wd1 = '0;
    reset2 = 1'b0; we2 = 1'b0; re2 = 1'b0; init2 = 1'b0; add2 = '0; wd2 = '0;
    @(negedge clk);
    test_reset();
    test_write_read();
    test_collision();
    test_reset_mid_init();
    test_init_pulse();
    test_zero_mode();
    repeat (2) @(negedge clk);
    n_total++;
    if (exp1.size() != 0 || exp2.size() != 0)
      $display("FAIL reads_outstanding: %0d and %0d expected reads never returned", exp1.size(), exp2.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, %0d/%0d so far", n_pass, n_total);
    $fatal(1);
  end

endmodule
